// File: rtl/dcache_axi_bridge_if.sv
// AXI3 single-beat master bundle used between the dcache bridge and the SoC fabric.
interface dcache_axi_bridge_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata_axi;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_WIDTH-1:0] awid;
  logic [31:0]         awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [ID_WIDTH-1:0] wid;
  logic [31:0]         wdata_axi;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_WIDTH-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata_axi, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata_axi, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata_axi, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata_axi, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/dcache_axi_bridge.sv
// Single-outstanding bridge: one sram-like request becomes one single-beat AXI3 read or write.
//   state | meaning
//   IDLE  | addr_ok follows req; request latched on acceptance
//   RD_A  | arvalid held until arready
//   RD_D  | rready held until rvalid; capture read data
//   WR_AW | awvalid/wvalid raised together, each drops on its own handshake
//   WR_B  | bready held until bvalid
module dcache_axi_bridge #(
  parameter int                  ID_WIDTH = 4,
  parameter logic [ID_WIDTH-1:0] RD_ID    = '0,
  parameter logic [ID_WIDTH-1:0] WR_ID    = ID_WIDTH'(1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  dcache_axi_bridge_if.master axi
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B} state_e;

  state_e      state_q, state_d;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        data_ok_q, data_ok_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        accept, rdata_we;
  logic        aw_fire, w_fire;
  logic [3:0]  wstrb;

  assign accept  = (state_q == IDLE) && req_i && !rst;
  assign aw_fire = axi.awvalid && axi.awready;
  assign w_fire  = axi.wvalid && axi.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      data_ok_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_ok_q <= data_ok_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (accept) begin
        wr_q    <= wr_i;
        size_q  <= size_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (rdata_we) rdata_q <= axi.rdata_axi;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_ok_d = 1'b0;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_we  = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = wr_i ? WR_AW : RD_A;
      RD_A:  if (axi.arready) state_d = RD_D;
      RD_D: begin
        if (axi.rvalid) begin
          rdata_we  = 1'b1;
          data_ok_d = 1'b1;
          state_d   = IDLE;
        end
      end
      WR_AW: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        // Both channels may complete in the same cycle or in either order.
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_B;
        end
      end
      WR_B: begin
        if (axi.bvalid) begin
          data_ok_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  assign addr_ok_o = accept;
  assign data_ok_o = data_ok_q;
  assign rdata_o   = rdata_q;

  assign axi.arid    = RD_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = {1'b0, size_q};
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'd0;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = (state_q == RD_A);
  assign axi.rready  = (state_q == RD_D);

  assign axi.awid      = WR_ID;
  assign axi.awaddr    = addr_q;
  assign axi.awlen     = 4'd0;
  assign axi.awsize    = {1'b0, size_q};
  assign axi.awburst   = 2'b01;
  assign axi.awlock    = 2'd0;
  assign axi.awcache   = 4'd0;
  assign axi.awprot    = 3'd0;
  assign axi.awvalid   = (state_q == WR_AW) && !aw_done_q;
  assign axi.wid       = WR_ID;
  assign axi.wdata_axi = wdata_q;
  assign axi.wstrb     = wstrb;
  assign axi.wlast     = 1'b1;
  assign axi.wvalid    = (state_q == WR_AW) && !w_done_q;
  assign axi.bready    = (state_q == WR_B);

  // Response ids/codes are deliberately ignored; error responses complete normally.
  logic unused_resp;
  assign unused_resp = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp, wr_q};

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: reads, writes, strobes, backpressure, back-to-back, reset abort.
module tb_dcache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        addr_ok, data_ok;

  int n_chk  = 0;
  int n_pass = 0;

  dcache_axi_bridge_if #(.ID_WIDTH(4)) axi ();

  dcache_axi_bridge #(.ID_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req),
    .wr_i      (wr),
    .size_i    (size),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .addr_ok_o (addr_ok),
    .data_ok_o (data_ok),
    .axi       (axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // Advance to the next falling edge; inputs change here and outputs are sampled #1 later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
    req = r; wr = w; size = s; addr = a; wdata = d;
  endtask

  initial begin
    logic [1:0]  sv_size [5];
    logic [31:0] sv_addr [5];
    logic [3:0]  sv_strb [5];
    sv_size = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd3};
    sv_addr = '{32'h0000_0100, 32'h0000_0101, 32'h0000_0102, 32'h0000_0200, 32'h0000_0301};
    sv_strb = '{4'b0001, 4'b0010, 4'b0100, 4'b0011, 4'b1111};

    rst = 1'b1;
    set_req(1'b1, 1'b0, 2'd2, 32'h1234_5678, 32'h0);
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata_axi = 32'h0;
    axi.rid = '0; axi.rresp = 2'd0; axi.rlast = 1'b1;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = 2'd0;

    cyc(); cyc(); settle();
    check("rst_addr_ok", 32'(addr_ok), 32'd0);
    check("rst_data_ok", 32'(data_ok), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 32'd0);
    check("const_len_burst", {axi.arlen, axi.awlen, axi.arburst, axi.awburst}, 32'h0005);
    check("const_wlast", 32'(axi.wlast), 32'd1);

    // Read word, minimum latency.
    cyc(); rst = 1'b0;
    set_req(1'b1, 1'b0, 2'd2, 32'h1FC0_0010, 32'h0); axi.arready = 1'b1; settle();
    check("rd_addr_ok", 32'(addr_ok), 32'd1);
    cyc(); set_req(1'b0, 1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0); settle();
    check("rd_arvalid", 32'(axi.arvalid), 32'd1);
    check("rd_araddr", axi.araddr, 32'h1FC0_0010);
    check("rd_arsize", 32'(axi.arsize), 32'd2);
    check("rd_arid", 32'(axi.arid), 32'd0);
    cyc(); axi.rvalid = 1'b1; axi.rdata_axi = 32'hDEAD_BEEF; settle();
    check("rd_rready", 32'(axi.rready), 32'd1);
    check("rd_arvalid_low", 32'(axi.arvalid), 32'd0);
    check("rd_no_early_ok", 32'(data_ok), 32'd0);
    cyc(); axi.rvalid = 1'b0; axi.rdata_axi = 32'h0; settle();
    check("rd_data_ok", 32'(data_ok), 32'd1);
    check("rd_rdata", rdata, 32'hDEAD_BEEF);
    cyc(); settle();
    check("rd_ok_one_cycle", 32'(data_ok), 32'd0);
    check("rd_rdata_hold", rdata, 32'hDEAD_BEEF);

    // Write byte.
    cyc(); set_req(1'b1, 1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000);
    axi.awready = 1'b1; axi.wready = 1'b1; settle();
    check("wb_addr_ok", 32'(addr_ok), 32'd1);
    cyc(); set_req(1'b0, 1'b0, 2'd2, 32'h0, 32'h0); settle();
    check("wb_valids", {axi.awvalid, axi.wvalid}, 32'd3);
    check("wb_awaddr", axi.awaddr, 32'h8000_0003);
    check("wb_awsize", 32'(axi.awsize), 32'd0);
    check("wb_wstrb", 32'(axi.wstrb), 32'h8);
    check("wb_wdata", axi.wdata_axi, 32'hAB00_0000);
    check("wb_ids", {axi.awid, axi.wid}, 32'h11);
    cyc(); axi.bvalid = 1'b1; axi.bresp = 2'b10; settle();
    check("wb_bready", 32'(axi.bready), 32'd1);
    check("wb_valids_low", {axi.awvalid, axi.wvalid}, 32'd0);
    cyc(); axi.bvalid = 1'b0; axi.bresp = 2'b00; settle();
    check("wb_data_ok", 32'(data_ok), 32'd1);
    check("wb_rdata_unchanged", rdata, 32'hDEAD_BEEF);
    cyc(); settle();
    check("wb_ok_one_cycle", 32'(data_ok), 32'd0);

    // Split AW/W: W accepted immediately, AW stalled three cycles.
    cyc(); set_req(1'b1, 1'b1, 2'd1, 32'h0000_0102, 32'h5A5A_0000);
    axi.awready = 1'b0; axi.wready = 1'b1; settle();
    check("sp_addr_ok", 32'(addr_ok), 32'd1);
    cyc(); set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0); settle();
    check("sp_valids_c1", {axi.awvalid, axi.wvalid}, 32'd3);
    check("sp_wstrb", 32'(axi.wstrb), 32'hC);
    for (int i = 0; i < 2; i++) begin
      cyc(); settle();
      check("sp_w_dropped", {axi.awvalid, axi.wvalid, axi.bready}, 32'b100);
      check("sp_awaddr_stable", axi.awaddr, 32'h0000_0102);
    end
    cyc(); axi.awready = 1'b1; settle();
    check("sp_aw_accept", {axi.awvalid, axi.wvalid, axi.bready}, 32'b100);
    cyc(); axi.bvalid = 1'b1; settle();
    check("sp_bready", {axi.awvalid, axi.bready}, 32'b01);
    cyc(); axi.bvalid = 1'b0; settle();
    check("sp_data_ok", 32'(data_ok), 32'd1);
    cyc(); settle();
    check("sp_ok_one_cycle", 32'(data_ok), 32'd0);

    // AR backpressure with req toggling on a different address.
    cyc(); set_req(1'b1, 1'b0, 2'd2, 32'h1000_0020, 32'h0); axi.arready = 1'b0; settle();
    check("bp_addr_ok", 32'(addr_ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      cyc(); set_req(i[0] ? 1'b0 : 1'b1, 1'b0, 2'd0, 32'h2000_0040, 32'h0); settle();
      check("bp_no_accept", 32'(addr_ok), 32'd0);
      check("bp_araddr", {axi.araddr[31:1], axi.arvalid}, 32'h1000_0021);
    end
    cyc(); req = 1'b0; axi.arready = 1'b1; settle();
    check("bp_arsize", 32'(axi.arsize), 32'd2);
    cyc(); axi.rvalid = 1'b1; axi.rdata_axi = 32'h1234_5678; axi.rresp = 2'b11; settle();
    check("bp_rready", 32'(axi.rready), 32'd1);
    cyc(); axi.rvalid = 1'b0; axi.rresp = 2'b00; settle();
    check("bp_data_ok", 32'(data_ok), 32'd1);
    check("bp_rdata", rdata, 32'h1234_5678);
    cyc(); settle();
    check("bp_single_ok", {axi.arvalid, data_ok}, 32'd0);

    // Back-to-back: second request (write) held through the first data_ok.
    cyc(); set_req(1'b1, 1'b0, 2'd2, 32'h0000_0030, 32'h0); settle();
    check("bb_addr_ok1", 32'(addr_ok), 32'd1);
    cyc(); set_req(1'b1, 1'b1, 2'd2, 32'h0000_0040, 32'h55AA_55AA);
    axi.awready = 1'b1; axi.wready = 1'b1; settle();
    check("bb_busy_ar", {addr_ok, axi.arvalid}, 32'b01);
    check("bb_araddr", axi.araddr, 32'h0000_0030);
    cyc(); axi.rvalid = 1'b1; axi.rdata_axi = 32'h1111_1111; settle();
    check("bb_busy_r", 32'(addr_ok), 32'd0);
    cyc(); axi.rvalid = 1'b0; settle();
    check("bb_ok_and_accept", {data_ok, addr_ok}, 32'b11);
    check("bb_rdata", rdata, 32'h1111_1111);
    cyc(); set_req(1'b0, 1'b0, 2'd0, 32'h0, 32'h0); settle();
    check("bb_aw", {axi.awvalid, axi.wvalid, data_ok}, 32'b110);
    check("bb_awaddr", axi.awaddr, 32'h0000_0040);
    check("bb_wstrb", 32'(axi.wstrb), 32'hF);
    check("bb_wdata", axi.wdata_axi, 32'h55AA_55AA);
    cyc(); axi.bvalid = 1'b1; settle();
    check("bb_bready", 32'(axi.bready), 32'd1);
    cyc(); axi.bvalid = 1'b0; settle();
    check("bb_data_ok2", 32'(data_ok), 32'd1);
    check("bb_rdata_after_wr", rdata, 32'h1111_1111);

    // Strobe table for sizes/offsets.
    for (int i = 0; i < 5; i++) begin
      cyc(); set_req(1'b1, 1'b1, sv_size[i], sv_addr[i], 32'hA5A5_A5A5); settle();
      cyc(); req = 1'b0; settle();
      check($sformatf("strb_%0d", i), 32'(axi.wstrb), 32'(sv_strb[i]));
      check($sformatf("strb_awsize_%0d", i), 32'(axi.awsize), 32'({1'b0, sv_size[i]}));
      cyc(); axi.bvalid = 1'b1;
      cyc(); axi.bvalid = 1'b0; settle();
      check($sformatf("strb_ok_%0d", i), 32'(data_ok), 32'd1);
    end

    // Reset while waiting for R: transfer abandoned, no data_ok, next read works.
    cyc(); set_req(1'b1, 1'b0, 2'd2, 32'h0000_0050, 32'h0); axi.arready = 1'b1;
    cyc(); req = 1'b0; settle();
    check("rr_arvalid", 32'(axi.arvalid), 32'd1);
    cyc(); rst = 1'b1; settle();
    check("rr_rready_before", 32'(axi.rready), 32'd1);
    cyc(); rst = 1'b0; set_req(1'b1, 1'b0, 2'd2, 32'h0000_0060, 32'h0); settle();
    check("rr_after_rst", {axi.rready, data_ok, axi.arvalid}, 32'd0);
    check("rr_idle_accept", 32'(addr_ok), 32'd1);
    check("rr_rdata_cleared", rdata, 32'h0);
    cyc(); req = 1'b0; settle();
    check("rr_araddr", {axi.araddr[31:1], axi.arvalid}, 32'h0000_0061);
    cyc(); axi.rvalid = 1'b1; axi.rdata_axi = 32'hCAFE_F00D; settle();
    cyc(); axi.rvalid = 1'b0; settle();
    check("rr_data_ok", 32'(data_ok), 32'd1);
    check("rr_rdata", rdata, 32'hCAFE_F00D);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache_axi_bridge.md
# dcache_axi_bridge

Single-outstanding bridge between the data cache's memory-side sram-like port and the SoC AXI3 master interface. It sits directly downstream of the data cache. Each accepted sram-like request becomes exactly one single-beat AXI read (AR→R) or write (AW+W→B), and the bridge returns a one-cycle data_ok pulse when the transfer completes. The instruction path may instantiate a second copy with read-only traffic.

## Interface
Parameters:
- ID_WIDTH, 4, width of all AXI id fields
- RD_ID, 0, constant driven on arid
- WR_ID, 1, constant driven on awid and wid

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  1  sram-like request valid
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word
- addr  in  32  byte address, passed to AXI unmodified
- wdata  in  32  write data, lane-aligned by the requester
- rdata  out  32  read data, valid while data_ok is high
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  one-cycle completion pulse
- arid / araddr / arsize  out  ID_WIDTH / 32 / 3  read address; arsize = {1'b0, size}
- arvalid  out  1;  arready  in  1
- rid / rdata_axi / rresp / rlast  in  ID_WIDTH / 32 / 2 / 1  read data channel
- rvalid  in  1;  rready  out  1
- awid / awaddr / awsize  out  ID_WIDTH / 32 / 3  write address; awsize = {1'b0, size}
- awvalid  out  1;  awready  in  1
- wid / wdata_axi / wstrb / wlast  out  ID_WIDTH / 32 / 4 / 1  write data; wlast is constant 1
- wvalid  out  1;  wready  in  1
- bid / bresp  in  ID_WIDTH / 2  write response
- bvalid  in  1;  bready  out  1
- arlen, awlen  out  4  constant 0
- arburst, awburst  out  2  constant 2'b01
- arlock, awlock  out  2  constant 0
- arcache, awcache  out  4  constant 0
- arprot, awprot  out  3  constant 0

## Operation
- FSM states:
  - IDLE: addr_ok = req, combinational. When req is high, latch wr, size, addr, wdata. Go to RD_A if wr = 0, otherwise to WR_AW.
  - RD_A: arvalid = 1. On arvalid & arready, go to RD_D.
  - RD_D: rready = 1. On rvalid, latch rdata_axi into the rdata register, set the data_ok register, go to IDLE.
  - WR_AW: awvalid and wvalid assert together. Each deasserts on its own handshake, tracked by flags aw_done and w_done. Once both are done (same cycle or different cycles), go to WR_B.
  - WR_B: bready = 1. On bvalid, set the data_ok register, go to IDLE.
- data_ok is a register and is high for exactly one cycle, the cycle after the R or B handshake.
- rdata holds its value until the next R handshake. After a write, rdata is unchanged.
- wstrb is computed from the latched size and addr[1:0]:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: addr[1] ? 4'b1100 : 4'b0011
  - size 2: 4'b1111
  - size 3: treated as size 2
- rresp, bresp, rid, bid and rlast are not checked. An error response still completes normally with data_ok.
- All AXI address, data and strobe outputs come from the latched request, never from the live inputs. Changes on the live inputs after acceptance have no effect.
- No request is accepted outside IDLE (addr_ok = 0). There is at most one outstanding transaction.

## Timing
- Reset values: state IDLE; arvalid, awvalid, wvalid, rready, bready, data_ok = 0; rdata = 0; aw_done = w_done = 0; all latched fields = 0. addr_ok is 0 during reset whatever req is.
- rst mid-transaction abandons the transfer immediately: valids/readies drop the next cycle and no data_ok is generated. Recovery of the AXI slave is the system's responsibility.
- Minimum read latency, with arready = 1 and rvalid arriving the cycle after the AR handshake:
  - cycle 0: addr_ok
  - cycle 1: AR handshake
  - cycle 2: R handshake
  - cycle 3: data_ok
- Minimum write latency, with awready = wready = 1 and bvalid the cycle after:
  - cycle 0: addr_ok
  - cycle 1: AW and W handshakes
  - cycle 2: B handshake
  - cycle 3: data_ok
- A new request may be accepted in the same cycle data_ok is high, since the FSM is already in IDLE.
- Once asserted, arvalid, awvalid and wvalid stay high, with stable payload, until their handshake.

## Test plan
- Read word: req=1, wr=0, size=2, addr=0x1FC0_0010, arready=1, rvalid one cycle after AR with rdata_axi=0xDEADBEEF → araddr=0x1FC0_0010, arsize=3'b010, data_ok pulses once with rdata=0xDEADBEEF, 4 cycles from addr_ok to data_ok inclusive.
- Write byte: wr=1, size=0, addr=0x8000_0003, wdata=0xAB00_0000 → awaddr=0x8000_0003, awsize=0, wstrb=4'b1000, wlast=1, exactly one data_ok after bvalid.
- Split AW/W: awready held 0 for 3 cycles, wready=1 immediately → wvalid drops after 1 cycle, awvalid held with stable awaddr until it is accepted, bready only afterwards, one data_ok.
- Backpressure: arready=0 for 5 cycles, then 1; req toggled with a new addr meanwhile → addr_ok stays 0, araddr keeps the original address, a single transaction completes.
- Back-to-back: second req held high through the first data_ok → second addr_ok in the same cycle as the first data_ok; both complete in order.
- Reset in RD_D: rst asserted for 1 cycle before rvalid → rready=0 and state IDLE the next cycle, no data_ok; a following read completes normally.
